pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Sequences the pipeline front end from the hazard-detection output and the EX-stage branch resolution.
- Turns a single-cycle hazard flag into a multi-cycle stall. Drives PC write-enable, IF/ID hold and flush, and ID/EX control flush.
- Sits between HazardDetection and the PC, IF/ID and ID/EX registers of the pipelined processor.
- Optionally counts inserted bubbles for performance inspection.

Parameters:
- STALL_CYCLES, 2, number of consecutive stall cycles per detected hazard (no forwarding: producer must leave EX/MEM); legal range 1..15.
- PERF_W, 16, width of the bubble counter (used only with the optional feature).

Ports:
- clock  input  1  pipeline clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- hasHazard  input  1  data-hazard flag from HazardDetection (ID vs EX dependency).
- branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- PCWrite  output  1  PC write-enable.
- IF_ID_Hold  output  1  hold the IF/ID register contents.
- IF_ID_Flush  output  1  zero the IF/ID register.
- ID_EX_CtrlFlush  output  1  zero the ID/EX control bits (insert bubble).
- stall_active  output  1  the front end is stalled this cycle.
- bubble_count  output  PERF_W  bubbles inserted since reset.

Behaviour:
- Internal state: `state` ∈ {RUN, STALL}, plus a down-counter `cnt` of 4 bits.
- Outputs are combinational from `state`, `hasHazard` and `branch_taken`. There is no output latency: a response appears in the same cycle as its cause.
- reset low, asynchronously, regardless of clock:
  - state=RUN, cnt=0, bubble_count=0.
  - While reset is low, forced outputs: PCWrite=0, IF_ID_Hold=0, IF_ID_Flush=0, ID_EX_CtrlFlush=0, stall_active=0.
  - Reset mid-stall abandons the stall. After release, the first edge evaluates from RUN.
- RUN, priority order:
  1. branch_taken=1 (flush cycle):
     - PCWrite=1, IF_ID_Flush=1, ID_EX_CtrlFlush=1, IF_ID_Hold=0, stall_active=0.
     - Next state RUN.
     - hasHazard is ignored: the dependent instruction is squashed.
  2. hasHazard=1 (stall cycle):
     - PCWrite=0, IF_ID_Hold=1, ID_EX_CtrlFlush=1, IF_ID_Flush=0, stall_active=1.
     - If STALL_CYCLES=1, next state RUN.
     - Otherwise next state STALL with cnt=STALL_CYCLES-1.
  3. Neither: PCWrite=1, all others 0. Next state RUN.
- STALL:
  - branch_taken=1 aborts the stall:
    - Flush-cycle outputs as in RUN rule 1.
    - Next state RUN, cnt=0.
  - Otherwise:
    - Stall-cycle outputs as in RUN rule 2, whatever hasHazard is.
    - If cnt==1, next state RUN and cnt=0.
    - Else cnt=cnt-1.
- Total stall length per hazard is exactly STALL_CYCLES cycles.
- On return to RUN, hasHazard is re-sampled. A still-present hazard starts a new full stall: back-to-back stalls are allowed, with no gap cycle.
- IF_ID_Hold and IF_ID_Flush are never both 1. PCWrite=0 only when stall_active=1 or reset is low.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - bubble_count increments by 1 on every rising edge at which ID_EX_CtrlFlush=1 and reset is high.
  - The count covers both stall and flush bubbles.
  - It saturates at 2^PERF_W-1 and does not wrap.
- Undefined: no counter register is built and bubble_count is tied to 0.

Test Plan:
- Reset: hold reset=0 for 3 cycles, pulse hasHazard and branch_taken → all outputs 0. After release, idle inputs give PCWrite=1 and the others 0.
- Single hazard (STALL_CYCLES=2): hasHazard=1 for cycle T only → PCWrite=0, IF_ID_Hold=1, ID_EX_CtrlFlush=1 in cycles T and T+1; PCWrite=1 at T+2.
- Persistent hazard: hasHazard=1 for cycles T..T+3 → stall_active=1 for T..T+3 with no gap; returns to RUN at T+4 once hasHazard=0.
- Branch priority: hasHazard=1 and branch_taken=1 in RUN at T → PCWrite=1, IF_ID_Flush=1, ID_EX_CtrlFlush=1, IF_ID_Hold=0; no stall at T+1.
- Stall abort and mid-stall reset:
  - branch_taken=1 at T+1 of a stall → flush outputs at T+1 and RUN at T+2.
  - Separately, reset=0 asserted mid-STALL → outputs go to 0 immediately and state is RUN after release.
- Counter (HAZARD_PERF_CNT_EN, PERF_W=2): five single hazards (10 bubbles) → bubble_count reads 3 and holds at 3. Without the macro it reads 0 throughout.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Purpose:
//   Sequences the pipeline front end from the HazardDetection flag and the
//   EX-stage branch resolution. A one-cycle hazard flag becomes a stall of
//   STALL_CYCLES cycles. A taken branch flushes IF/ID and ID/EX, and it
//   overrides both a new hazard and a stall that is already in progress.
//   All outputs are combinational from the current state and the inputs, so
//   a response appears in the same cycle as its cause.
//
// Parameters:
//   STALL_CYCLES : number of stall cycles per detected hazard (1..15)
//   PERF_W       : width of the bubble counter
//
// Ports:
//   clock           in   pipeline clock, rising edge
//   reset           in   asynchronous, active-low reset
//   hasHazard       in   ID-vs-EX data hazard flag
//   branch_taken    in   branch/jump resolved taken in EX this cycle
//   PCWrite         out  PC write-enable
//   IF_ID_Hold      out  hold the IF/ID register
//   IF_ID_Flush     out  zero the IF/ID register
//   ID_EX_CtrlFlush out  zero the ID/EX control bits (insert a bubble)
//   stall_active    out  the front end is stalled this cycle
//   bubble_count    out  bubbles inserted since reset (saturating)
//
// Handshake note: there is no valid/ready pairing here. The inputs are
//   level flags that are sampled every cycle, and the outputs are level
//   controls that are valid in the same cycle.
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   When defined, bubble_count counts the rising edges at which
//   ID_EX_CtrlFlush=1 and saturates at 2^PERF_W-1. When undefined, no
//   counter register is built and bubble_count is tied to 0.
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int unsigned STALL_CYCLES = 2,
  parameter int unsigned PERF_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hasHazard,
  input  logic              branch_taken,
  output logic              PCWrite,
  output logic              IF_ID_Hold,
  output logic              IF_ID_Flush,
  output logic              ID_EX_CtrlFlush,
  output logic              stall_active,
  output logic [PERF_W-1:0] bubble_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // The hazard cycle itself is the first stall cycle, so the counter is
  // loaded with the number of cycles that remain after it.
  localparam logic [3:0] LP_RELOAD = 4'(STALL_CYCLES - 1);
  localparam bit         LP_SINGLE = (STALL_CYCLES == 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_pc_write;
  logic w_hold;
  logic w_flush;
  logic w_ctrl_flush;
  logic w_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pc_write   = 1'b0;
    w_hold       = 1'b0;
    w_flush      = 1'b0;
    w_ctrl_flush = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken) begin
          // Any dependent instruction is squashed, so hasHazard is ignored.
          w_pc_write   = 1'b1;
          w_flush      = 1'b1;
          w_ctrl_flush = 1'b1;
          w_state_nxt  = RUN;
          w_cnt_nxt    = 4'd0;
        end else if (hasHazard) begin
          w_hold       = 1'b1;
          w_ctrl_flush = 1'b1;
          w_stall      = 1'b1;
          if (LP_SINGLE) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = STALL;
            w_cnt_nxt   = LP_RELOAD;
          end
        end else begin
          w_pc_write = 1'b1;
        end
      end
      STALL: begin
        if (branch_taken) begin
          w_pc_write   = 1'b1;
          w_flush      = 1'b1;
          w_ctrl_flush = 1'b1;
          w_state_nxt  = RUN;
          w_cnt_nxt    = 4'd0;
        end else begin
          w_hold       = 1'b1;
          w_ctrl_flush = 1'b1;
          w_stall      = 1'b1;
          // A count of 0 cannot occur in STALL. It is treated like 1 so that
          // a corrupted count cannot lock up the front end.
          if (r_cnt <= 4'd1) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // While reset is low every control output is forced to 0 without waiting
  // for a clock edge.
  assign PCWrite         = reset & w_pc_write;
  assign IF_ID_Hold      = reset & w_hold;
  assign IF_ID_Flush     = reset & w_flush;
  assign ID_EX_CtrlFlush = reset & w_ctrl_flush;
  assign stall_active    = reset & w_stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_bubble_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bubble_count <= '0;
    end else if (ID_EX_CtrlFlush && (r_bubble_count != {PERF_W{1'b1}})) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign bubble_count = r_bubble_count;
`else
  assign bubble_count = '0;
`endif

endmodule
